matrix_job_host: RTL and testbench

Host-side initiator for the UART matrix-multiply accelerator protocol. It holds operand matrices A and B, loaded through a local write port. On `start` it streams one job over a byte-level UART transmitter: the size byte N, then N² bytes of A row-major, then N² bytes of B row-major. It then collects the N² result bytes (low 8 bits of each product cell, row-major) from a byte-level UART receiver into a result buffer readable by the surrounding test/host logic. It sits between on-chip control logic and a BaudRateGenerator/Uart8Transmitter/Uart8Receiver trio cabled to the accelerator board.

---
 rtl/matrix_job_host.sv | 178 +++++++++++++++++
 tb/tb_matrix_job_host.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_job_host.sv
// Host-side job sequencer for the UART matrix-multiply accelerator: holds A/B locally,
// streams N, A, B byte by byte with an idle gap after each, then collects N*N result bytes.
module matrix_job_host #(
    parameter int MAX_SIZE       = 10,
    parameter int GAP_CYCLES     = 12500,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int AW             = $clog2(MAX_SIZE * MAX_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic          load_sel,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    input  logic [7:0]    size,
    input  logic          start,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy,
    input  logic          tx_done,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          rx_err,
    input  logic [AW-1:0] res_addr,
    output logic [7:0]    res_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);
    localparam int DEPTH = MAX_SIZE * MAX_SIZE;
    localparam int GW    = $clog2(GAP_CYCLES + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_RECV, S_DONE} state_t;

    state_t        state_q;
    logic [7:0]    mem_a [DEPTH];
    logic [7:0]    mem_b [DEPTH];
    logic [7:0]    mem_r [DEPTH];
    logic [7:0]    n_q, nsq_q, sidx_q;
    logic [AW-1:0] ridx_q;
    logic [GW-1:0] gap_q;
    logic [TW-1:0] tmo_q;
    logic          tx_done_q, rx_done_q;
    logic          tx_start_q, busy_q, done_q, err_q;
    logic [1:0]    err_code_q;
    logic [7:0]    tx_data_q, res_data_q;

    logic          tx_edge, rx_edge, r_we, last_byte;
    logic [AW-1:0] a_off, b_off;
    logic [7:0]    cur_byte;

    assign tx_edge   = tx_done & ~tx_done_q;
    assign rx_edge   = rx_done & ~rx_done_q;
    assign last_byte = ({1'b0, sidx_q} == {nsq_q, 1'b0});
    // An error seen together with a byte edge discards the byte.
    assign r_we      = (state_q == S_RECV) && rx_edge && !rx_err && !rst;

    // Byte stream layout: index 0 is N, then N*N bytes of A, then N*N bytes of B.
    always_comb begin
        a_off    = AW'(sidx_q - 8'd1);
        b_off    = AW'(sidx_q - 8'd1 - nsq_q);
        cur_byte = n_q;
        if (sidx_q != 8'd0) begin
            if (sidx_q <= nsq_q) cur_byte = mem_a[a_off];
            else                 cur_byte = mem_b[b_off];
        end
    end

    always_ff @(posedge clk) begin
        if (load_en && !busy_q && !rst && int'(load_addr) < DEPTH) begin
            if (load_sel) mem_b[load_addr] <= load_data;
            else          mem_a[load_addr] <= load_data;
        end
        if (r_we) mem_r[ridx_q] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= 8'd0;
            nsq_q      <= 8'd0;
            sidx_q     <= 8'd0;
            ridx_q     <= '0;
            gap_q      <= '0;
            tmo_q      <= '0;
            tx_done_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            res_data_q <= 8'd0;
        end else begin
            tx_done_q  <= tx_done;
            rx_done_q  <= rx_done;
            done_q     <= 1'b0;
            res_data_q <= (int'(res_addr) < DEPTH) ? mem_r[res_addr] : 8'd0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q        <= size;
                        nsq_q      <= 8'(size * size);
                        sidx_q     <= 8'd0;
                        err_q      <= 1'b0;
                        err_code_q <= 2'd0;
                        if (size < 8'd2 || size > 8'(MAX_SIZE)) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'd1;
                            done_q     <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (!tx_start_q) begin
                        tx_data_q <= cur_byte;
                        if (!tx_busy) tx_start_q <= 1'b1;
                    end else if (tx_edge) begin
                        tx_start_q <= 1'b0;
                        gap_q      <= '0;
                        state_q    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        if (last_byte) begin
                            ridx_q  <= '0;
                            tmo_q   <= '0;
                            state_q <= S_RECV;
                        end else begin
                            sidx_q  <= sidx_q + 8'd1;
                            state_q <= S_SEND;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                S_RECV: begin
                    if (rx_err) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'd2;
                        state_q    <= S_DONE;
                    end else if (rx_edge) begin
                        ridx_q <= ridx_q + 1'b1;
                        tmo_q  <= '0;
                        if (ridx_q == AW'(nsq_q - 8'd1)) state_q <= S_DONE;
                    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'd3;
                        state_q    <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign res_data = res_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
endmodule

// File: tb/tb_matrix_job_host.sv
// Directed bench for matrix_job_host with a behavioural UART transmitter responder.
module tb_matrix_job_host;
    localparam int MAXS = 10;
    localparam int GAP  = 20;
    localparam int TMO  = 1000;
    localparam int AW   = 7;

    logic          clk = 1'b0;
    logic          rst, load_en, load_sel, start, tx_start, tx_busy, tx_done;
    logic          rx_done, rx_err, busy, done, err;
    logic [AW-1:0] load_addr, res_addr;
    logic [7:0]    load_data, size, tx_data, rx_data, res_data;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    matrix_job_host #(.MAX_SIZE(MAXS), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr),
        .load_data(load_data), .size(size), .start(start), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
        .res_addr(res_addr), .res_data(res_data), .busy(busy), .done(done), .err(err),
        .err_code(err_code)
    );

    typedef struct {
        logic [7:0] size;
        logic       exp_err;
        logic [1:0] exp_code;
    } size_vec_t;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sent_q[$];
    int         tx_hold = 1;
    int         cyc = 0;
    int         fall_cyc = -1;
    int         gap_bad = 0;
    int         done_cnt = 0;
    logic       done_err = 1'b0;
    logic [1:0] done_code = 2'd0;
    logic       done_busy = 1'b0;
    logic       tx_start_prev = 1'b0;

    // Output monitor: spacing between transmit requests and done pulse capture.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tx_start === 1'b1 && tx_start_prev === 1'b0 && fall_cyc >= 0 && (cyc - fall_cyc) < GAP + 1)
            gap_bad = gap_bad + 1;
        if (tx_start === 1'b0 && tx_start_prev === 1'b1) fall_cyc = cyc;
        tx_start_prev = tx_start;
        if (done === 1'b1) begin
            done_cnt  = done_cnt + 1;
            done_err  = err;
            done_code = err_code;
            done_busy = busy;
        end
    end

    // Transmitter model: accepts a request, stays busy, then raises tx_done for tx_hold cycles.
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && !tx_busy && rst === 1'b0) begin
                sent_q.push_back(tx_data);
                tx_busy = 1'b1;
                repeat (3) @(negedge clk);
                tx_done = 1'b1;
                repeat (tx_hold) @(negedge clk);
                tx_done = 1'b0;
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(input logic s, input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1; load_sel = s; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic load_ab2();
        for (int i = 0; i < 4; i++) begin
            load(1'b0, AW'(i), 8'(i + 1));
            load(1'b1, AW'(i), 8'(i + 5));
        end
    endtask

    task automatic start_job(input logic [7:0] n);
        @(negedge clk);
        size = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sent(input int n, input string nm);
        int k;
        k = 0;
        while (sent_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check(nm, sent_q.size(), n);
    endtask

    task automatic send_rx(input logic [7:0] d, input int hold, input logic e);
        @(negedge clk);
        rx_data = d; rx_done = 1'b1; rx_err = e;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0; rx_err = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done(input int base, input int bound, input string nm);
        int k;
        k = 0;
        while (done_cnt == base && k < bound) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check({nm, "_done_pulses"}, done_cnt - base, 1);
        check({nm, "_busy_at_done"}, done_busy, 0);
    endtask

    task automatic read_res(input logic [AW-1:0] a, output logic [7:0] d);
        @(negedge clk);
        res_addr = a;
        @(negedge clk);
        d = res_data;
    endtask

    size_vec_t  sv[4];
    logic [7:0] exp1[9];
    logic [7:0] r2[4];
    logic [7:0] rd;
    int         base;

    initial begin
        sv[0] = '{8'd0,   1'b1, 2'd1};
        sv[1] = '{8'd1,   1'b1, 2'd1};
        sv[2] = '{8'd11,  1'b1, 2'd1};
        sv[3] = '{8'd255, 1'b1, 2'd1};
        exp1  = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        r2    = '{8'd19, 8'd22, 8'd43, 8'd50};

        rst = 1'b1; load_en = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = 8'd0;
        size = 8'd0; start = 1'b0; rx_data = 8'd0; rx_done = 1'b0; rx_err = 1'b0; res_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_res_data", res_data, 0);
        rst = 1'b0;

        load_ab2();

        // Out-of-range sizes: immediate error, no transmission.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            size = sv[i].size; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("badsize_done", done, 1);
            check("badsize_err", err, sv[i].exp_err);
            check("badsize_code", err_code, sv[i].exp_code);
            check("badsize_busy", busy, 0);
            @(negedge clk);
            check("badsize_done_width", done, 0);
            check("badsize_no_tx", tx_start, 0);
        end
        check("badsize_sent_none", sent_q.size(), 0);

        // Job 1: 2x2 product, clean run.
        base = done_cnt;
        start_job(8'd2);
        check("job1_busy_t1", busy, 1);
        check("job1_tx_start_t1", tx_start, 0);
        check("job1_err_cleared", err, 0);
        wait_sent(9, "job1_sent");
        repeat (GAP + 30) @(negedge clk);
        for (int i = 0; i < 9; i++) check("job1_byte", sent_q[i], exp1[i]);
        for (int i = 0; i < 4; i++) send_rx(r2[i], 1, 1'b0);
        wait_done(base, 200, "job1");
        check("job1_err", done_err, 0);
        check("job1_code", done_code, 0);
        for (int i = 0; i < 4; i++) begin
            read_res(AW'(i), rd);
            check("job1_res", rd, r2[i]);
        end
        check("gap_spacing", gap_bad, 0);

        // Timeout: N=3 with only 5 of 9 results returned.
        for (int i = 0; i < 9; i++) begin
            load(1'b0, AW'(i), 8'(10 + i));
            load(1'b1, AW'(i), 8'(30 + i));
        end
        sent_q.delete();
        base = done_cnt;
        start_job(8'd3);
        wait_sent(19, "tmo_sent");
        repeat (GAP + 30) @(negedge clk);
        check("tmo_byte_n", sent_q[0], 3);
        check("tmo_byte_a_last", sent_q[9], 18);
        check("tmo_byte_b_first", sent_q[10], 30);
        check("tmo_byte_b_last", sent_q[18], 38);
        for (int i = 0; i < 5; i++) send_rx(8'(100 + i), 1, 1'b0);
        repeat (TMO - 60) @(negedge clk);
        check("tmo_not_early", done_cnt - base, 0);
        wait_done(base, 200, "tmo");
        check("tmo_err", done_err, 1);
        check("tmo_code", done_code, 3);
        read_res(AW'(4), rd);
        check("tmo_res4", rd, 104);

        // Framing error during the second result byte.
        load_ab2();
        sent_q.delete();
        base = done_cnt;
        start_job(8'd2);
        wait_sent(9, "rxerr_sent");
        repeat (GAP + 30) @(negedge clk);
        send_rx(8'hAA, 1, 1'b0);
        send_rx(8'hBB, 1, 1'b1);
        wait_done(base, 100, "rxerr");
        check("rxerr_err", done_err, 1);
        check("rxerr_code", done_code, 2);
        read_res(AW'(0), rd);
        check("rxerr_res0", rd, 8'hAA);
        read_res(AW'(1), rd);
        check("rxerr_res1_kept", rd, 101);

        // Long tx_done/rx_done pulses, plus a stray rx byte during SEND.
        tx_hold = 8;
        sent_q.delete();
        base = done_cnt;
        start_job(8'd2);
        send_rx(8'hEE, 8, 1'b0);
        wait_sent(9, "hold_sent");
        repeat (GAP + 40) @(negedge clk);
        check("hold_sent_exact", sent_q.size(), 9);
        for (int i = 0; i < 9; i++) check("hold_byte", sent_q[i], exp1[i]);
        for (int i = 0; i < 4; i++) send_rx(8'(9 - i), 8, 1'b0);
        wait_done(base, 100, "hold");
        check("hold_code", done_code, 0);
        for (int i = 0; i < 4; i++) begin
            read_res(AW'(i), rd);
            check("hold_res", rd, 8'(9 - i));
        end
        tx_hold = 1;

        // Ignored load/start while busy, then reset mid-transmission.
        sent_q.delete();
        base = done_cnt;
        start_job(8'd2);
        load(1'b0, AW'(0), 8'h77);
        @(negedge clk);
        size = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sent(3, "rst_job_sent");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_no_done", done_cnt - base, 0);
        for (int i = 0; i < 3; i++) check("midrst_byte", sent_q[i], exp1[i]);
        sent_q.delete();
        start_job(8'd2);
        wait_sent(9, "post_rst_sent");
        repeat (GAP + 30) @(negedge clk);
        for (int i = 0; i < 9; i++) check("post_rst_byte", sent_q[i], exp1[i]);
        for (int i = 0; i < 4; i++) send_rx(8'(i + 1), 1, 1'b0);
        wait_done(base, 100, "post_rst");
        check("post_rst_code", done_code, 0);
        read_res(AW'(3), rd);
        check("post_rst_res3", rd, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
